// File: rtl/signext_pkg.sv
// Shared constants and types for the LEGv8 immediate-extension unit.
// Holds opcode patterns, field widths, the format class enum and the
// packed result payload carried through the register stage.
package signext_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 64;
  localparam int unsigned OP11_W  = 11;
  localparam int unsigned OP8_W   = 8;
  localparam int unsigned DT_W    = 9;
  localparam int unsigned CB_W    = 19;

  localparam logic [OP11_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OP11_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OP8_W-1:0]  OP_CBZ8 = 8'b10110100;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_D    = 2'd1,
    FMT_CB   = 2'd2
  } fmt_t;

  // Decode result: format class plus extended immediate
  typedef struct packed {
    fmt_t             fmt;
    logic [IMM_W-1:0] imm;
  } ext_res_t;

endpackage

// File: rtl/signext_if.sv
// Instruction/immediate bundle between the decode stage and signext_unit.
//   a     : instruction word (driven by master)
//   y     : combinational extended immediate
//   y_q   : y registered on rising clk
//   fmt_q : registered format class (0 none, 1 D-format, 2 CBZ)
interface signext_if;
  import signext_pkg::*;

  logic [INSTR_W-1:0] a;
  logic [IMM_W-1:0]   y;
  logic [IMM_W-1:0]   y_q;
  logic [1:0]         fmt_q;

  modport master (output a, input y, y_q, fmt_q);
  modport slave  (input a, output y, y_q, fmt_q);

endinterface

// File: rtl/signext_core.sv
// Pure combinational immediate decode.
//   a   : instruction word
//   y   : extended immediate (0 for unsupported opcodes)
//   fmt : format class of a
module signext_core
  import signext_pkg::*;
(
  input  logic [INSTR_W-1:0] a,
  output logic [IMM_W-1:0]   y,
  output fmt_t               fmt
);

  logic is_d;
  logic is_cb;

  assign is_d  = (a[31:21] == OP_LDUR) || (a[31:21] == OP_STUR);
  assign is_cb = (a[31:24] == OP_CBZ8);

  // Only the selected field reaches y, so ignored bits never leak into it.
  // The CBZ field includes a[23:21] and is zero-extended, not sign-extended.
  always_comb begin
    y   = '0;
    fmt = FMT_NONE;
    if (is_d) begin
      fmt = FMT_D;
      y   = {{(IMM_W-DT_W){a[20]}}, a[20:12]};
    end else if (is_cb) begin
      fmt = FMT_CB;
      y   = {{(IMM_W-CB_W-2){1'b0}}, a[23:5], 2'b00};
    end
  end

endmodule

// File: rtl/signext_unit.sv
// LEGv8 immediate-extension unit: combinational decode plus one register
// stage holding the immediate and its format class.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset (clears y_q/fmt_q only)
//   bus   : slave side of signext_if (a in; y, y_q, fmt_q out)
module signext_unit
  import signext_pkg::*;
(
  input logic       clk,
  input logic       reset,
  signext_if.slave  bus
);

  ext_res_t res_c;
  ext_res_t res_q;

  signext_core u_core (
    .a   (bus.a),
    .y   (res_c.imm),
    .fmt (res_c.fmt)
  );

  // Pipeline copy of the decode result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_c;
    end
  end

  assign bus.y     = res_c.imm;
  assign bus.y_q   = res_q.imm;
  assign bus.fmt_q = res_q.fmt;

endmodule

// File: tb/tb_signext_unit.sv
// Scoreboard bench for signext_unit: driver pushes expected registered
// results, a monitor pops and compares after each rising edge.
module tb_signext_unit;

  typedef struct {
    logic [63:0] y;
    logic [1:0]  fmt;
    logic [31:0] a;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_q[$];

  signext_if bus ();

  signext_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: decode by arithmetic on opcode values and field magnitudes
  function automatic exp_t ref_model(input logic [31:0] a);
    exp_t        e;
    int unsigned op11;
    int unsigned op8;
    longint      dt;
    longint      fld;
    op11  = int'(a >> 21);
    op8   = int'(a >> 24);
    e.a   = a;
    e.y   = 64'd0;
    e.fmt = 2'd0;
    if (op11 == 32'h7C2 || op11 == 32'h7C0) begin
      dt = longint'((a >> 12) & 32'h1FF);
      if (dt >= 256) dt = dt - 512;
      e.y   = 64'(dt);
      e.fmt = 2'd1;
    end else if (op8 == 32'hB4) begin
      fld   = longint'((a >> 5) & 32'h7FFFF);
      e.y   = 64'(fld * 4);
      e.fmt = 2'd2;
    end
    return e;
  endfunction

  // Apply a at the falling edge, check y combinationally, queue the registered result
  task automatic drive(input logic [31:0] v, input logic [63:0] ey, input logic [1:0] ef);
    exp_t e;
    @(negedge clk);
    bus.a = v;
    e.a   = v;
    e.y   = ey;
    e.fmt = ef;
    exp_q.push_back(e);
    #1;
    check64($sformatf("y a=%h", v), bus.y, ey);
  endtask

  // Monitor: registered outputs must reflect the previous cycle's input
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check64($sformatf("y_q a=%h", e.a), bus.y_q, e.y);
        check64($sformatf("fmt_q a=%h", e.a), 64'(bus.fmt_q), 64'(e.fmt));
      end
    end
  end

  logic [31:0] dir_a  [11];
  logic [63:0] dir_y  [11];
  logic [1:0]  dir_f  [11];
  logic [31:0] neg_ldur;

  initial begin
    dir_a[0]  = 32'b11111000010_000000001_00_00001_00000; dir_y[0]  = 64'h1;                dir_f[0]  = 2'd1;
    dir_a[1]  = 32'b11111000010_100000000_00_00001_00000; dir_y[1]  = 64'hFFFFFFFFFFFFFF00; dir_f[1]  = 2'd1;
    dir_a[2]  = 32'b11111000000_000000001_00_00001_00000; dir_y[2]  = 64'h1;                dir_f[2]  = 2'd1;
    dir_a[3]  = 32'b11111000000_100000000_00_00001_00000; dir_y[3]  = 64'hFFFFFFFFFFFFFF00; dir_f[3]  = 2'd1;
    dir_a[4]  = 32'b10110100_000_0000000000000001_00000;  dir_y[4]  = 64'h4;                dir_f[4]  = 2'd2;
    dir_a[5]  = 32'b10110100_111_0000000000000001_00000;  dir_y[5]  = 64'h1C0004;           dir_f[5]  = 2'd2;
    dir_a[6]  = 32'b10110100_000_1000000000000000_00000;  dir_y[6]  = 64'h20000;            dir_f[6]  = 2'd2;
    dir_a[7]  = 32'b10110100_111_1000000000000000_00000;  dir_y[7]  = 64'h1E0000;           dir_f[7]  = 2'd2;
    dir_a[8]  = 32'b00111000010_000000001_00_00001_00000; dir_y[8]  = 64'h0;                dir_f[8]  = 2'd0;
    dir_a[9]  = 32'b10001011000_00001_000100_00001_00010; dir_y[9]  = 64'h0;                dir_f[9]  = 2'd0;
    dir_a[10] = 32'b11111000010_000000001_11_11111_11111; dir_y[10] = 64'h1;                dir_f[10] = 2'd1;
    neg_ldur  = dir_a[1];

    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    bus.a   = 32'd0;

    // Reset state
    #12;
    check64("reset y_q", bus.y_q, 64'd0);
    check64("reset fmt_q", 64'(bus.fmt_q), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors, one per cycle
    for (int i = 0; i < 11; i++) drive(dir_a[i], dir_y[i], dir_f[i]);

    // Asynchronous reset mid-operation
    drive(neg_ldur, 64'hFFFFFFFFFFFFFF00, 2'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check64("async rst y_q", bus.y_q, 64'd0);
    check64("async rst fmt_q", 64'(bus.fmt_q), 64'd0);
    check64("async rst y", bus.y, 64'hFFFFFFFFFFFFFF00);
    @(posedge clk);
    #1;
    check64("held rst y_q", bus.y_q, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      exp_t e;
      e.a   = neg_ldur;
      e.y   = 64'hFFFFFFFFFFFFFF00;
      e.fmt = 2'd1;
      exp_q.push_back(e);
    end

    // Randomized vectors biased toward the decoded opcodes
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      exp_t        m;
      r = $urandom();
      case ($urandom_range(0, 3))
        0: r = {11'b11111000010, r[20:0]};
        1: r = {11'b11111000000, r[20:0]};
        2: r = {8'b10110100, r[23:0]};
        default: ;
      endcase
      m = ref_model(r);
      drive(r, m.y, m.fmt);
    end

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signext_unit.md
Name: signext_unit

Overview:
- Immediate-extension block for the LEGv8/ARMv8 single-cycle datapath (decode stage).
- Takes a 32-bit instruction word and produces the 64-bit immediate for D-format loads/stores (LDUR, STUR) and for CBZ.
- All other opcodes produce 0.
- The combinational output feeds the ALU/branch adder in the same cycle.
- A registered copy of the result and the format class is provided for pipelined use and debug.

Parameters:
- None. Widths are fixed: instruction 32 bits, immediate 64 bits.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  32  instruction word.
- y  output  64  combinational extended immediate.
- y_q  output  64  y registered on rising clk.
- fmt_q  output  2  registered format class: 0 = none, 1 = D-format, 2 = CBZ.

Behaviour:
- Decode of y is purely combinational with zero latency. y settles within the same cycle a changes, independent of clk and reset.
- D-format:
  - Match when a[31:21] == 11111000010 (LDUR) or a[31:21] == 11111000000 (STUR).
  - y = {{55{a[20]}}, a[20:12]}, i.e. sign-extended DT_address.
  - Bits a[11:0] are ignored.
- CBZ:
  - Match when a[31:24] == 10110100. Bits a[23:21] are don't-care for the match.
  - y = {43'b0, a[23:5], 2'b00}.
  - The 19-bit field a[23:5] is taken including a[23:21], shifted left by 2 and zero-extended. No sign extension is applied.
- Any other opcode → y = 64'h0. This includes LDURB (00111000010), ADD (10001011000) and all R/I/B formats.
- Matching priority:
  - The D-format and CBZ opcode sets are disjoint.
  - If neither matches, the result is 0.
  - No X propagation from unused bits: an X on an ignored field must not reach y.
- Registered path:
  - On each rising clk, y_q ← y and fmt_q ← format class of a. One-cycle latency.
  - reset low (asynchronous assert): y_q = 0 and fmt_q = 0 immediately. Release is synchronous to the next rising edge.
  - reset asserted mid-operation clears the registers and does not affect y.
- No handshake and no state machine.

Decomposition:
- Shared package signext_pkg holds:
  - opcode constants OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000, OP_CBZ8 = 8'b10110100;
  - enum fmt_t {FMT_NONE = 0, FMT_D = 1, FMT_CB = 2};
  - width constants INSTR_W = 32, IMM_W = 64.
- Sub-module signext_core holds the pure combinational decode (a → y, fmt).
- The top module wraps signext_core with the async-reset register stage.

Test Plan:
- LDUR a = 32'b11111000010_000000001_00_00001_00000 → y = 64'h1. LDUR with DT = 100000000 → y = 64'hFFFFFFFFFFFFFF00. fmt_q = 1 after the next clk edge.
- STUR a = 32'b11111000000_000000001_00_00001_00000 → y = 64'h1. STUR with DT = 100000000 → y = 64'hFFFFFFFFFFFFFF00.
- CBZ a = 10110100000_0000000000000001_00000 → y = 64'h4. With a[23:21] = 111 → y = 64'h1C0004. Field bit a[20] set, a[23:21] = 000 → y = 64'h20000. Same with a[23:21] = 111 → y = 64'h1E0000. fmt_q = 2.
- Non-members: LDURB 32'b00111000010_000000001_00_00001_00000 → y = 0. ADD 32'b10001011000_00001_000100_00001_00010 → y = 0. fmt_q = 0.
- Reset: drive a = LDUR negative case, clock once (y_q = FFFFFFFFFFFFFF00). Assert reset low between edges → y_q = 0 and fmt_q = 0 without a clock edge, while y stays FFFFFFFFFFFFFF00. Release → y_q reloads on the next edge.
- Register latency: change a every cycle through the vectors above → y_q always equals the previous cycle's y.
